// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard and debug controller: a 3-slot destination scoreboard
// detects RAW hazards at ID, and a RUN/HALTING/HALTED/STEP machine gates issue.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        resume_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_bubble,
    output logic        hazard,
    output logic [1:0]  state,
    output logic [2:0]  inflight,
    output logic [15:0] stall_cnt,
    output logic [31:0] issue_cnt
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STALL_W = 16;
    localparam int unsigned ISSUE_W = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_STEP    = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } slot_t;

    state_e               state_q, state_d;
    slot_t                ex_q, ex_d;
    slot_t                mem_q, mem_d;
    slot_t                wb_q, wb_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [ISSUE_W-1:0]   issue_cnt_q, issue_cnt_d;

    logic                 hazard_c;
    logic                 can_issue_c;
    logic                 issue_c;
    logic                 inflight_empty_c;
    logic                 stall_state_c;

    function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt);
        return s.valid && ((s.rd == rs) || (s.rd == rt));
    endfunction

    // RAW check against all three pending writes; WB still counts because the
    // register file is written only at the edge that closes the WB cycle.
    always_comb begin
        hazard_c = 1'b0;
        if (!reset && id_valid) begin
            hazard_c = slot_hit(ex_q, id_rs, id_rt)
                     | slot_hit(mem_q, id_rs, id_rt)
                     | slot_hit(wb_q, id_rs, id_rt);
        end
    end

    // Issue permission: RUN unless a halt is being requested, or a pending single step.
    always_comb begin
        can_issue_c = 1'b0;
        case (state_q)
            ST_RUN:  can_issue_c = ~halt_req;
            ST_STEP: can_issue_c = 1'b1;
            default: can_issue_c = 1'b0;
        endcase
        issue_c          = can_issue_c & ~hazard_c & ~reset;
        inflight_empty_c = ~(ex_q.valid | mem_q.valid | wb_q.valid);
        stall_state_c    = (state_q == ST_RUN) || (state_q == ST_STEP);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) state_d = ST_HALTING;
            end
            ST_HALTING: begin
                if (inflight_empty_c) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (resume_req)    state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (issue_c) state_d = ST_HALTING;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Pipeline control outputs
    always_comb begin
        pc_en       = issue_c;
        ifid_en     = issue_c;
        idex_bubble = ~issue_c;
        hazard      = hazard_c;
    end

    // Scoreboard shift and counters
    always_comb begin
        ex_d = '0;
        if (issue_c) begin
            ex_d.valid = id_valid & id_regwrite & (id_rd != '0);
            ex_d.rd    = id_rd;
        end
        mem_d = ex_q;
        wb_d  = mem_q;

        stall_cnt_d = stall_cnt_q;
        if (hazard_c && stall_state_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end

        issue_cnt_d = issue_cnt_q;
        if (issue_c && id_valid) begin
            issue_cnt_d = issue_cnt_q + ISSUE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign state     = state_q;
    assign inflight  = {wb_q.valid, mem_q.valid, ex_q.valid};
    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a list-of-pending-writes model checked on every
// negedge, plus directed instruction sequences with literal expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        resume_req = 1'b0;
    logic        pc_en, ifid_en, idex_bubble, hazard;
    logic [1:0]  state;
    logic [2:0]  inflight;
    logic [15:0] stall_cnt;
    logic [31:0] issue_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .halt_req(halt_req),
        .step_req(step_req), .resume_req(resume_req), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_bubble(idex_bubble), .hazard(hazard), .state(state), .inflight(inflight),
        .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending destination registers, youngest first (0 = nothing pending).
    int          m_pend [3] = '{0, 0, 0};
    int          m_state = 0;
    int unsigned m_stall = 0;
    logic [31:0] m_issue = '0;
    bit          m_valid = 1'b0;

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (m_pend[i]) if (m_pend[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_hazard();
        return !reset && id_valid && (pending(id_rs) || pending(id_rt));
    endfunction

    function automatic bit exp_issue();
        return !reset && !exp_hazard() && ((m_state == 0 && !halt_req) || m_state == 3);
    endfunction

    function automatic logic [2:0] exp_inflight();
        return {m_pend[2] != 0, m_pend[1] != 0, m_pend[0] != 0};
    endfunction

    always @(posedge clk) begin
        bit hz, iss;
        hz  = exp_hazard();
        iss = exp_issue();
        if (reset) begin
            m_pend  = '{0, 0, 0};
            m_state = 0;
            m_stall = 0;
            m_issue = '0;
            m_valid = 1'b1;
        end else begin
            if (hz && (m_state == 0 || m_state == 3) && m_stall < 65535) m_stall++;
            if (iss && id_valid) m_issue++;
            case (m_state)
                0: if (halt_req) m_state = 1;
                1: if (exp_inflight() == 3'b000) m_state = 2;
                2: if (resume_req) m_state = 0; else if (step_req) m_state = 3;
                default: if (iss) m_state = 1;
            endcase
            m_pend[2] = m_pend[1];
            m_pend[1] = m_pend[0];
            m_pend[0] = (iss && id_valid && id_regwrite) ? int'(id_rd) : 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("pc_en",       32'(pc_en),       32'(exp_issue()));
            check("ifid_en",     32'(ifid_en),     32'(exp_issue()));
            check("idex_bubble", 32'(idex_bubble), 32'(!exp_issue()));
            check("hazard",      32'(hazard),      32'(exp_hazard()));
            check("state",       32'(state),       32'(m_state));
            check("inflight",    32'(inflight),    32'(exp_inflight()));
            check("stall_cnt",   32'(stall_cnt),   m_stall);
            check("issue_cnt",   issue_cnt,        m_issue);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction and hold it until it issues; reports stall cycles.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_regwrite = 1'b1;
        for (int k = 0; k < 8 && !done; k++) begin
            #1;
            if (pc_en) done = 1'b1;
            else stalls++;
            tick();
        end
        check("send_issued", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int s, tot, cnt;
        logic [31:0] base;

        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_rd = 5'd3; id_regwrite = 1'b1;
        tick();
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_bubble", 32'(idex_bubble), 32'd1);
        check("rst_hazard", 32'(hazard), 32'd0);
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_issue", issue_cnt, 32'd0);
        reset = 1'b0;
        idle(2);

        // ADD R3,R1,R2 ; SUB R4,R3,R2
        send(5'd1, 5'd2, 5'd3, s);
        send(5'd3, 5'd2, 5'd4, s);
        check("raw_ex_stalls", 32'(s), 32'd3);
        check("raw_ex_stall_cnt", 32'(stall_cnt), 32'd3);
        check("raw_ex_issue_cnt", issue_cnt, 32'd2);
        idle(3);

        // ADD R3 ; AND R5 ; OR R6,R3,R2
        send(5'd1, 5'd2, 5'd3, s);
        send(5'd1, 5'd2, 5'd5, s);
        send(5'd3, 5'd2, 5'd6, s);
        check("raw_mem_stalls", 32'(s), 32'd2);
        check("raw_mem_stall_cnt", 32'(stall_cnt), 32'd5);
        idle(3);

        base = issue_cnt;
        tot = 0;
        for (int r = 3; r <= 6; r++) begin
            send(5'd1, 5'd2, 5'(r), s);
            tot += s;
        end
        check("indep_stalls", 32'(tot), 32'd0);
        check("indep_issues", issue_cnt - base, 32'd4);
        idle(3);

        // R0 destination never creates a dependency
        send(5'd1, 5'd2, 5'd0, s);
        send(5'd0, 5'd1, 5'd4, s);
        check("r0_stalls", 32'(s), 32'd0);
        idle(3);

        // Halt with three writes in flight
        send(5'd1, 5'd2, 5'd7, s);
        send(5'd1, 5'd2, 5'd8, s);
        send(5'd1, 5'd2, 5'd9, s);
        check("halt_inflight_full", 32'(inflight), 32'd7);
        id_valid = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        cnt = 0;
        while (state == 2'd1 && cnt < 10) begin
            cnt++;
            tick();
        end
        check("halting_cycles", 32'(cnt), 32'd3);
        check("halted_state", 32'(state), 32'd2);
        check("halted_inflight", 32'(inflight), 32'd0);

        // Requests and instructions are ignored while halted
        base = issue_cnt;
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd10; id_regwrite = 1'b1;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halted_hold", 32'(state), 32'd2);
        check("halted_no_issue", issue_cnt - base, 32'd0);

        // Single step
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("step_state", 32'(state), 32'd3);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (state != 2'd2 && cnt < 12);
        check("step_back_halted", 32'(state), 32'd2);
        check("step_one_issue", issue_cnt - base, 32'd1);

        // Resume wins over step
        resume_req = 1'b1;
        step_req = 1'b1;
        tick();
        resume_req = 1'b0;
        step_req = 1'b0;
        check("resume_state", 32'(state), 32'd0);

        // Self-dependent chain: 3 stalls per 4 cycles, enough to saturate
        id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd3; id_rd = 5'd3; id_regwrite = 1'b1;
        repeat (87500) tick();
        check("stall_saturated", 32'(stall_cnt), 32'h0000_FFFF);
        cnt = 0;
        while (!hazard && cnt < 5) begin
            tick();
            cnt++;
        end
        check("hazard_before_reset", 32'(hazard), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_stall", 32'(stall_cnt), 32'd0);
        check("post_rst_issue", issue_cnt, 32'd0);
        check("post_rst_hazard", 32'(hazard), 32'd0);
        check("post_rst_pc_en", 32'(pc_en), 32'd1);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock, all state updates on posedge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high; sampled on posedge clk.
REQ-003 SHALL provide: id_valid  in  1  IF/ID holds a real instruction.
REQ-004 SHALL provide: id_rs, id_rt, id_rd  in  5 each  source and destination fields of IF/ID instruction.
REQ-005 SHALL provide: id_regwrite  in  1  IF/ID instruction writes id_rd.
REQ-006 SHALL provide: halt_req, step_req, resume_req  in  1 each  debug control pulses.
REQ-007 SHALL provide: pc_en, ifid_en  out  1 each  PC and IF/ID load enables.
REQ-008 SHALL provide: idex_bubble  out  1  load zero/NOP into ID/EX this cycle.
REQ-009 SHALL provide: hazard  out  1  combinational RAW hazard flag.
REQ-010 SHALL provide: state  out  2  RUN=0, HALTING=1, HALTED=2, STEP=3.
REQ-011 SHALL provide: inflight  out  3  valid bits of scoreboard slots {WB,MEM,EX}.
REQ-012 SHALL provide: stall_cnt  out  16  hazard stall cycles; issue_cnt  out  32  issued instructions.

Function
REQ-013 Scoreboard SHALL be a 3-slot shift pipeline EX->MEM->WB, each slot {valid, rd}, advancing every cycle.
REQ-014 Slot EX SHALL load {id_valid & id_regwrite & (id_rd!=0), id_rd} on issue; {0,0} otherwise; rd=0 writes never tracked.
REQ-015 hazard SHALL = id_valid & any valid slot (EX, MEM or WB) with rd equal to id_rs or id_rt; WB included because register file write lands at the edge after the WB cycle.
REQ-016 issue SHALL = (state==RUN or STEP-not-yet-issued) & ~hazard & ~reset.
REQ-017 On issue: pc_en=1, ifid_en=1, idex_bubble=0; otherwise pc_en=0, ifid_en=0, idex_bubble=1.
REQ-018 id_valid=0 in RUN SHALL still issue (pipeline advances, EX slot loads {0,0}).
REQ-019 Maximum consecutive hazard stall for one instruction SHALL be 3 cycles.
REQ-020 RUN: halt_req -> HALTING next cycle; no issue in the halt_req cycle.
REQ-021 HALTING: no issue; -> HALTED in the cycle after inflight==3'b000.
REQ-022 HALTED: resume_req -> RUN; else step_req -> STEP; resume_req wins when both asserted.
REQ-023 STEP: issue exactly one instruction (waiting through hazards), then -> HALTING next cycle.
REQ-024 halt_req SHALL be ignored outside RUN; step_req and resume_req ignored outside HALTED.
REQ-025 stall_cnt SHALL increment each cycle hazard=1 in RUN or STEP, saturating at 16'hFFFF.
REQ-026 issue_cnt SHALL increment on every issue with id_valid=1, wrapping modulo 2^32.
REQ-027 Outputs pc_en, ifid_en, idex_bubble, hazard SHALL be combinational from registered state and current inputs; all other outputs registered.

Reset
REQ-028 While reset=1: pc_en=0, ifid_en=0, idex_bubble=1, hazard=0 regardless of other inputs.
REQ-029 On posedge with reset=1: state=RUN, all scoreboard slots {0,0}, inflight=0, stall_cnt=0, issue_cnt=0.
REQ-030 Reset asserted in any state, including mid-stall or STEP, SHALL override all transitions and requests.

Verification
REQ-031 ADD R3,R1,R2 then SUB R4,R3,R2 back-to-back -> hazard=1 for 3 cycles, pc_en=0, idex_bubble=1; SUB issues 4th cycle; stall_cnt=3.
REQ-032 ADD R3,R1,R2; AND R5,R1,R2; OR R6,R3,R2 -> OR stalls exactly 2 cycles; independent stream R3..R6 -> zero stalls, issue_cnt increments every cycle.
REQ-033 ADD R0,R1,R2 followed by SUB R4,R0,R1 -> hazard=0, no stall.
REQ-034 halt_req with 3 instructions in flight -> state HALTING for 3 cycles then HALTED, inflight=000; step_req -> one issue, issue_cnt+1, back to HALTED after drain; resume_req with step_req same cycle -> RUN.
REQ-035 Force hazard for 70000 cycles -> stall_cnt holds 16'hFFFF; reset during stall -> next cycle state=RUN, counters 0, hazard=0.
